// File: rtl/exec_pkg.sv
// Shared widths and ALU operation codes for the execution core.
package exec_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int DM_DEPTH = 32;
  localparam int RIDX_W   = $clog2(NREG);
  localparam int DADDR_W  = $clog2(DM_DEPTH);

  localparam logic [5:0] ALU_ADD   = 6'h01;
  localparam logic [5:0] ALU_SUB   = 6'h02;
  localparam logic [5:0] ALU_SLL   = 6'h03;
  localparam logic [5:0] ALU_SLT   = 6'h04;
  localparam logic [5:0] ALU_SLTU  = 6'h05;
  localparam logic [5:0] ALU_XOR   = 6'h06;
  localparam logic [5:0] ALU_SRL   = 6'h07;
  localparam logic [5:0] ALU_SRA   = 6'h08;
  localparam logic [5:0] ALU_OR    = 6'h09;
  localparam logic [5:0] ALU_AND   = 6'h0A;
  localparam logic [5:0] ALU_ADDI  = 6'h0B;
  localparam logic [5:0] ALU_SLTI  = 6'h0C;
  localparam logic [5:0] ALU_SLTIU = 6'h0D;
  localparam logic [5:0] ALU_XORI  = 6'h0E;
  localparam logic [5:0] ALU_ORI   = 6'h0F;
  localparam logic [5:0] ALU_ANDI  = 6'h10;
  localparam logic [5:0] ALU_SLLI  = 6'h11;
  localparam logic [5:0] ALU_SRLI  = 6'h12;
  localparam logic [5:0] ALU_SRAI  = 6'h13;
  localparam logic [5:0] ALU_BEQ   = 6'h14;
  localparam logic [5:0] ALU_BNE   = 6'h15;
  localparam logic [5:0] ALU_BGE   = 6'h16;
  localparam logic [5:0] ALU_BLT   = 6'h17;

endpackage

// File: rtl/exec_if.sv
// Control-unit to execution-core bundle: decoded fields in, branch flags out.
interface exec_if;
  import exec_pkg::*;

  logic [RIDX_W-1:0] read_reg_num1;
  logic [RIDX_W-1:0] read_reg_num2;
  logic [RIDX_W-1:0] write_reg_num1;
  logic [5:0]        alu_control;
  logic [XLEN-1:0]   imm_val;
  logic [4:0]        shamt;
  logic              lb;
  logic              sw;
  logic              lui_control;
  logic [XLEN-1:0]   imm_val_lui;
  logic              jump;
  logic [XLEN-1:0]   return_address;
  logic              beq_control;
  logic              bne_control;
  logic              bgeq_control;
  logic              blt_control;
  logic [DADDR_W-1:0] read_data_addr_dm;
  logic              beq;
  logic              bneq;
  logic              bge;
  logic              blt;

  modport master (
    output read_reg_num1, read_reg_num2, write_reg_num1, alu_control, imm_val, shamt,
           lb, sw, lui_control, imm_val_lui, jump, return_address,
           beq_control, bne_control, bgeq_control, blt_control,
    input  read_data_addr_dm, beq, bneq, bge, blt
  );

  modport slave (
    input  read_reg_num1, read_reg_num2, write_reg_num1, alu_control, imm_val, shamt,
           lb, sw, lui_control, imm_val_lui, jump, return_address,
           beq_control, bne_control, bgeq_control, blt_control,
    output read_data_addr_dm, beq, bneq, bge, blt
  );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU; register, immediate and shamt forms share one case.
module exec_alu
  import exec_pkg::*;
(
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      shamt_i,
  output logic [XLEN-1:0] result_o
);

  // operation select; unknown codes yield zero
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << b_i[4:0];
      ALU_SLT:   result_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU:  result_o = XLEN'(a_i < b_i);
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> b_i[4:0];
      ALU_SRA:   result_o = $signed(a_i) >>> b_i[4:0];
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_ADDI:  result_o = a_i + imm_i;
      ALU_SLTI:  result_o = XLEN'($signed(a_i) < $signed(imm_i));
      ALU_SLTIU: result_o = XLEN'(a_i < imm_i);
      ALU_XORI:  result_o = a_i ^ imm_i;
      ALU_ORI:   result_o = a_i | imm_i;
      ALU_ANDI:  result_o = a_i & imm_i;
      ALU_SLLI:  result_o = a_i << shamt_i;
      ALU_SRLI:  result_o = a_i >> shamt_i;
      ALU_SRAI:  result_o = $signed(a_i) >>> shamt_i;
      ALU_BEQ:   result_o = XLEN'(a_i == b_i);
      ALU_BNE:   result_o = XLEN'(a_i != b_i);
      ALU_BGE:   result_o = XLEN'($signed(a_i) >= $signed(b_i));
      ALU_BLT:   result_o = XLEN'($signed(a_i) < $signed(b_i));
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_dmem.sv
// 32-word data memory: combinational read, clocked write, byte-load extension.
module exec_dmem
  import exec_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DADDR_W-1:0] addr_i,
  input  logic               we_i,
  input  logic [XLEN-1:0]    wdata_i,
  output logic [XLEN-1:0]    load_val_o
);

  logic [XLEN-1:0] mem_q [DM_DEPTH];
  logic [XLEN-1:0] rd_word;
  logic            unused_hi;

  assign rd_word    = mem_q[addr_i];
  assign load_val_o = {{(XLEN-8){rd_word[7]}}, rd_word[7:0]};
  // byte loads never consume the upper part of the word
  assign unused_hi  = ^rd_word[XLEN-1:8];

  // storage; a same-cycle load sees the pre-write word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/exec_regfile.sv
// 32x32 register file with x0 hardwired to zero and the write-back source mux.
module exec_regfile
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] rs1_i,
  input  logic [RIDX_W-1:0] rs2_i,
  input  logic [RIDX_W-1:0] rd_i,
  input  logic              we_i,
  input  logic              jump_i,
  input  logic [XLEN-1:0]   ret_addr_i,
  input  logic              lui_i,
  input  logic [XLEN-1:0]   lui_val_i,
  input  logic              lb_i,
  input  logic [XLEN-1:0]   load_val_i,
  input  logic [XLEN-1:0]   alu_result_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] wb_d;

  // write-back source, highest priority first
  always_comb begin
    if (jump_i)     wb_d = ret_addr_i;
    else if (lui_i) wb_d = lui_val_i;
    else if (lb_i)  wb_d = load_val_i;
    else            wb_d = alu_result_i;
  end

  assign rs1_data_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
  assign rs2_data_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];

  // register array update; writes to x0 are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (rd_i != '0)) begin
      regs_q[rd_i] <= wb_d;
    end
  end

endmodule

// File: rtl/exec_core.sv
// Single-cycle execution core: register file, ALU and data memory glue.
module exec_core
  import exec_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  exec_if.slave  bus
);

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] load_val;
  logic            reg_we;
  logic            res_one;

  assign reg_we = ~(bus.sw | bus.beq_control | bus.bne_control |
                    bus.bgeq_control | bus.blt_control);

  exec_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .rs1_i        (bus.read_reg_num1),
    .rs2_i        (bus.read_reg_num2),
    .rd_i         (bus.write_reg_num1),
    .we_i         (reg_we),
    .jump_i       (bus.jump),
    .ret_addr_i   (bus.return_address),
    .lui_i        (bus.lui_control),
    .lui_val_i    (bus.imm_val_lui),
    .lb_i         (bus.lb),
    .load_val_i   (load_val),
    .alu_result_i (alu_result),
    .rs1_data_o   (rs1_data),
    .rs2_data_o   (rs2_data)
  );

  exec_alu u_alu (
    .op_i     (bus.alu_control),
    .a_i      (rs1_data),
    .b_i      (rs2_data),
    .imm_i    (bus.imm_val),
    .shamt_i  (bus.shamt),
    .result_o (alu_result)
  );

  exec_dmem u_dmem (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (bus.imm_val[DADDR_W-1:0]),
    .we_i       (bus.sw),
    .wdata_i    (rs2_data),
    .load_val_o (load_val)
  );

  // branch flags: compare-style ALU result qualified by the matching strobe
  assign res_one               = (alu_result == XLEN'(1));
  assign bus.beq               = res_one & bus.beq_control;
  assign bus.bneq              = res_one & bus.bne_control;
  assign bus.bge               = res_one & bus.bgeq_control;
  assign bus.blt               = res_one & bus.blt_control;
  assign bus.read_data_addr_dm = bus.imm_val[DADDR_W-1:0];

endmodule

// File: tb/tb_exec_core.sv
// Scoreboard bench for exec_core with a behavioural architectural model.
module tb_exec_core;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exec_if bus();
  exec_core dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        lb, sw, lui;
    logic [31:0] lui_val;
    logic        jump;
    logic [31:0] ret;
    logic        bq, bn, bg, bl;
  } instr_t;

  typedef struct {
    logic [4:0] addr;
    logic [3:0] flags;
    string      tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];
  int          errors = 0;
  int          checks = 0;

  // architectural ALU: immediate/shift forms folded onto their base operation
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic [4:0] sh);
    int          base;
    int          amt;
    logic [31:0] y;
    base = int'(op);
    y    = b;
    amt  = int'(b[4:0]);
    case (op)
      6'h0B: begin base = 1;  y = imm; end
      6'h0C: begin base = 4;  y = imm; end
      6'h0D: begin base = 5;  y = imm; end
      6'h0E: begin base = 6;  y = imm; end
      6'h0F: begin base = 9;  y = imm; end
      6'h10: begin base = 10; y = imm; end
      6'h11: begin base = 3;  amt = int'(sh); end
      6'h12: begin base = 7;  amt = int'(sh); end
      6'h13: begin base = 8;  amt = int'(sh); end
      default: ;
    endcase
    case (base)
      1:  return a + y;
      2:  return a - y;
      3:  return a << amt;
      4:  return (int'(a) < int'(y)) ? 32'd1 : 32'd0;
      5:  return (a < y) ? 32'd1 : 32'd0;
      6:  return a ^ y;
      7:  return a >> amt;
      8:  return 32'(int'(a) >>> amt);
      9:  return a | y;
      10: return a & y;
      20: return (a == y) ? 32'd1 : 32'd0;
      21: return (a != y) ? 32'd1 : 32'd0;
      22: return (int'(a) >= int'(y)) ? 32'd1 : 32'd0;
      23: return (int'(a) < int'(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic instr_t mk();
    instr_t t;
    t = '{rs1:5'd0, rs2:5'd0, rd:5'd0, op:6'd0, imm:32'd0, shamt:5'd0, lb:1'b0, sw:1'b0,
          lui:1'b0, lui_val:32'd0, jump:1'b0, ret:32'd0, bq:1'b0, bn:1'b0, bg:1'b0, bl:1'b0};
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
  endtask

  // drive one instruction for one cycle, push expectation, retire into the model
  task automatic issue(input instr_t in, input string tag);
    logic [31:0]        a, b, res, wb;
    logic signed [7:0]  sb;
    exp_t               e;
    logic               one;
    bus.read_reg_num1  = in.rs1;
    bus.read_reg_num2  = in.rs2;
    bus.write_reg_num1 = in.rd;
    bus.alu_control    = in.op;
    bus.imm_val        = in.imm;
    bus.shamt          = in.shamt;
    bus.lb             = in.lb;
    bus.sw             = in.sw;
    bus.lui_control    = in.lui;
    bus.imm_val_lui    = in.lui_val;
    bus.jump           = in.jump;
    bus.return_address = in.ret;
    bus.beq_control    = in.bq;
    bus.bne_control    = in.bn;
    bus.bgeq_control   = in.bg;
    bus.blt_control    = in.bl;
    a   = m_reg[in.rs1];
    b   = m_reg[in.rs2];
    res = ref_alu(in.op, a, b, in.imm, in.shamt);
    one = (res == 32'd1);
    sb  = m_mem[in.imm[4:0]][7:0];
    if (in.jump)     wb = in.ret;
    else if (in.lui) wb = in.lui_val;
    else if (in.lb)  wb = 32'(sb);
    else             wb = res;
    e.addr  = in.imm[4:0];
    e.flags = {one & in.bq, one & in.bn, one & in.bg, one & in.bl};
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (in.sw) m_mem[in.imm[4:0]] = b;
      if (!(in.sw | in.bq | in.bn | in.bg | in.bl) && in.rd != 5'd0) m_reg[in.rd] = wb;
    end
    #1;
  endtask

  task automatic lui_to(input logic [4:0] rd, input logic [31:0] v, input string tag);
    instr_t t;
    t = mk(); t.rd = rd; t.lui = 1'b1; t.lui_val = v;
    issue(t, tag);
  endtask

  // observe a register through an equality branch against a known copy
  task automatic probe_reg(input logic [4:0] r, input string tag);
    instr_t t;
    logic [4:0] s;
    s = (r == 5'd31) ? 5'd30 : 5'd31;
    t = mk(); t.op = ALU_BEQ; t.bq = 1'b1; t.rs1 = r;
    if (m_reg[r] == 32'd0) begin
      t.rs2 = 5'd0;
    end else begin
      lui_to(s, m_reg[r], {tag, "_lui"});
      t.rs2 = s;
    end
    issue(t, tag);
  endtask

  task automatic probe_mem(input logic [4:0] addr, input string tag);
    instr_t t;
    t = mk(); t.lb = 1'b1; t.rd = 5'd29; t.imm = {27'd0, addr};
    issue(t, {tag, "_lb"});
    probe_reg(5'd29, tag);
  endtask

  // monitor: one expectation per cycle, compared on the falling edge
  initial begin
    exp_t       e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.read_data_addr_dm, bus.beq, bus.bneq, bus.bge, bus.blt};
        checks++;
        if (got !== {e.addr, e.flags}) begin
          errors++;
          $display("FAIL %s: got addr=%0d flags(beq,bneq,bge,blt)=%b, expected addr=%0d flags=%b",
                   e.tag, got[8:4], got[3:0], e.addr, e.flags);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    instr_t t;
    model_clear();
    t = mk();
    issue_idle: begin
      bus.read_reg_num1 = '0; bus.read_reg_num2 = '0; bus.write_reg_num1 = '0;
      bus.alu_control = '0; bus.imm_val = '0; bus.shamt = '0; bus.lb = 0; bus.sw = 0;
      bus.lui_control = 0; bus.imm_val_lui = '0; bus.jump = 0; bus.return_address = '0;
      bus.beq_control = 0; bus.bne_control = 0; bus.bgeq_control = 0; bus.blt_control = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int r = 0; r < 32; r++) probe_reg(5'(r), "reset_reg");
    for (int a = 0; a < 32; a++) probe_mem(5'(a), "reset_mem");

    lui_to(5'd1, 32'h0000_0005, "lui_x1");
    lui_to(5'd2, 32'hFFFF_FFFD, "lui_x2");
    t = mk(); t.op = ALU_ADD; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd = 5'd3; issue(t, "add");
    t = mk(); t.op = ALU_SLT; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd = 5'd4; issue(t, "slt");
    probe_reg(5'd3, "add_x3");
    probe_reg(5'd4, "slt_x4");

    t = mk(); t.sw = 1'b1; t.rs2 = 5'd2; t.imm = 32'd7; t.rd = 5'd6; issue(t, "sw7");
    t = mk(); t.lb = 1'b1; t.imm = 32'd7; t.rd = 5'd5; issue(t, "lb7");
    probe_reg(5'd5, "lb_x5");
    probe_mem(5'd7, "mem7");

    lui_to(5'd5, 32'h0000_0005, "lui_x5");
    t = mk(); t.op = ALU_BEQ; t.bq = 1'b1; t.rs1 = 5'd1; t.rs2 = 5'd5; t.rd = 5'd6;
    issue(t, "beq_taken");
    probe_reg(5'd6, "beq_nowrite");
    lui_to(5'd5, 32'h0000_0007, "lui_x5b");
    issue(t, "beq_not_taken");

    lui_to(5'd7, 32'hFFFF_FFFF, "lui_x7");
    lui_to(5'd8, 32'h0000_0001, "lui_x8");
    t = mk(); t.op = ALU_BGE; t.bg = 1'b1; t.rs1 = 5'd7; t.rs2 = 5'd8; issue(t, "bge_neg");
    t = mk(); t.op = ALU_BLT; t.bl = 1'b1; t.rs1 = 5'd7; t.rs2 = 5'd8; issue(t, "blt_neg");

    t = mk(); t.op = ALU_ADDI; t.imm = 32'd9; t.rd = 5'd0; issue(t, "addi_x0");
    probe_reg(5'd0, "x0_zero");
    t = mk(); t.jump = 1'b1; t.ret = 32'h44; t.rd = 5'd9; issue(t, "jal");
    probe_reg(5'd9, "jal_x9");

    for (int n = 0; n < 250; n++) begin
      t         = mk();
      t.rs1     = 5'($urandom_range(0, 31));
      t.rs2     = ($urandom_range(0, 3) == 0) ? t.rs1 : 5'($urandom_range(0, 31));
      t.rd      = 5'($urandom_range(0, 31));
      t.op      = 6'($urandom_range(0, 25));
      t.imm     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) - 32'd8 : $urandom;
      t.shamt   = 5'($urandom_range(0, 31));
      t.lb      = ($urandom_range(0, 5) == 0);
      t.sw      = ($urandom_range(0, 5) == 0);
      t.lui     = ($urandom_range(0, 7) == 0);
      t.lui_val = $urandom;
      t.jump    = ($urandom_range(0, 9) == 0);
      t.ret     = $urandom;
      t.bq      = ($urandom_range(0, 5) == 0);
      t.bn      = ($urandom_range(0, 5) == 0);
      t.bg      = ($urandom_range(0, 5) == 0);
      t.bl      = ($urandom_range(0, 5) == 0);
      issue(t, "rand_op");
      probe_reg(5'($urandom_range(0, 31)), "rand_reg");
      if ($urandom_range(0, 3) == 0) probe_mem(5'($urandom_range(0, 31)), "rand_mem");
    end

    for (int r = 1; r < 9; r++) lui_to(5'(r), 32'h1000_0000 + 32'(r), "prefill");
    t = mk(); t.sw = 1'b1; t.rs2 = 5'd3; t.imm = 32'd12; issue(t, "prefill_sw");
    fork
      begin
        #6;
        rst = 1'b0;
        model_clear();
      end
    join_none
    t = mk(); t.op = ALU_ADD; t.rs1 = 5'd1; t.rs2 = 5'd2; t.rd = 5'd10; issue(t, "lost_write");
    probe_reg(5'd1, "in_reset_x1");
    probe_reg(5'd10, "in_reset_x10");
    probe_mem(5'd12, "in_reset_mem12");
    rst = 1'b1;
    for (int r = 1; r < 32; r++) probe_reg(5'(r), "post_reset_reg");
    for (int a = 0; a < 32; a++) probe_mem(5'(a), "post_reset_mem");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_core.md
# exec_core

Single-cycle execution core of the RISC-V processor. It combines a 32x32 register file, a combinational 32-bit ALU and a 32-word data memory. It accepts decoded register numbers, immediates and control strobes from the control unit, and performs register write-back at the clock edge. It also returns branch-taken flags to the PC/control logic.

## Interface
Parameters:
- None. Widths are fixed: XLEN 32, 32 registers, 32 memory words.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_reg_num1  in  5  rs1 index.
- read_reg_num2  in  5  rs2 index.
- write_reg_num1  in  5  rd index.
- alu_control  in  6  ALU operation code (see Operation).
- imm_val  in  32  sign-extended I/S immediate; imm_val[4:0] is the data-memory word address.
- shamt  in  5  immediate shift amount.
- lb  in  1  load: rd <= memory data.
- sw  in  1  store: mem[imm_val[4:0]] <= rs2 data.
- lui_control, imm_val_lui  in  1, 32  LUI: rd <= imm_val_lui.
- jump, return_address  in  1, 32  JAL: rd <= return_address.
- beq_control, bne_control, bgeq_control, blt_control  in  1 each  branch instruction strobes.
- read_data_addr_dm  out  5  current memory address, equal to imm_val[4:0].
- beq, bneq, bge, blt  out  1 each  branch-taken flags.

## Operation
- Register file:
  - Two combinational read ports.
  - x0 always reads 0, and writes to x0 are discarded.
- ALU is combinational. Operands are a = rs1 data and b = rs2 data. Results per alu_control:
  - 0x01 ADD a+b; 0x02 SUB a-b.
  - 0x03 SLL a<<b[4:0].
  - 0x04 SLT (signed a<b); 0x05 SLTU (unsigned a<b).
  - 0x06 XOR; 0x07 SRL a>>b[4:0]; 0x08 SRA (arithmetic shift); 0x09 OR; 0x0A AND.
  - 0x0B ADDI, 0x0C SLTI, 0x0D SLTIU, 0x0E XORI, 0x0F ORI, 0x10 ANDI: same operations with b replaced by imm_val.
  - 0x11 SLLI, 0x12 SRLI, 0x13 SRAI: shift a by shamt.
  - 0x14 result = (a==b); 0x15 (a!=b); 0x16 signed a>=b; 0x17 signed a<b.
  - All other codes: result 0.
  - Arithmetic wraps modulo 2^32.
- Branch flags (combinational):
  - beq = (alu_result==1) & beq_control.
  - bneq, bge, blt are formed the same way with their respective strobes.
- Data memory:
  - 32 x 32-bit words.
  - Combinational read of mem[imm_val[4:0]].
  - Synchronous write when sw=1.
- Write-back data, by priority: jump → return_address; else lui_control → imm_val_lui; else lb → sign-extended mem word[7:0]; else alu_result.
- Register write enable = ~(sw | beq_control | bne_control | bgeq_control | blt_control).
- Simultaneous strobes resolve by the priority above. Branch and store strobes always suppress the register write.

## Timing
- Reset (rst=0, asynchronous): all 32 registers and all 32 memory words clear to 0.
  - Branch flags follow combinationally; with zeroed state and no strobes they are 0.
- Register write: lands on the rising edge. It is visible to reads from the next cycle on.
  - No write-to-read bypass in the same cycle; a same-cycle read returns the old value.
- Memory write: on the rising edge. A load from the same address in the same cycle returns the old word.
- Reads, ALU, flags and read_data_addr_dm: zero-latency combinational paths.
- Reset asserted mid-cycle clears state immediately. Any pending write is lost.

## Structure
- Shared package exec_pkg holds:
  - ALU opcode localparams (ALU_ADD … ALU_BLT);
  - XLEN=32;
  - NREG=32;
  - DM_DEPTH=32.
- Three sub-modules:
  - exec_regfile (reads, x0 handling, write-back mux);
  - exec_alu (pure combinational);
  - exec_dmem.
- Top-level exec_core:
  - connects the sub-modules;
  - forms write enable and branch flags.

## Test plan
- Reset, then read x1..x31 → all 0. mem[0..31] read via lb → 0.
- LUI x1=0x00000005, LUI x2=0xFFFFFFFD. Then ADD (0x01) rd=x3 → x3=0x00000002. SLT (0x04) rd=x4 → x4=0.
- sw with imm_val=7, rs2=x2 → mem[7]=0xFFFFFFFD. Next cycle lb imm_val=7 → rd=0xFFFFFFFD, read_data_addr_dm=7.
- alu_control=0x14, x1=x5, beq_control=1 → beq=1 and no register write. Change to x1≠x5 → beq=0.
- bgeq_control with 0x16, rs1=0xFFFFFFFF, rs2=1 → bge=0. blt_control with 0x17 on the same operands → blt=1.
- Write to x0 via ADDI imm 9 → x0 reads 0.
- jump=1 with return_address=0x44 → rd=0x44.
- Assert rst mid-run → all registers and memory read 0 immediately.
